// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch sequencer.
// Address/instruction widths match the 4096 x 19-bit instruction memory.
package fetch_pkg;
  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 19;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT,
    FAULT
  } fetch_state_t;
endpackage

// File: rtl/fetch_if.sv
// Fetch <-> memory/decode bus: imem read port, IR handshake, redirects.
// master is the fetch side, slave is the memory/decode/control side.
interface fetch_if;
  import fetch_pkg::*;

  addr_t  imem_addr;
  instr_t imem_instr;
  logic   ir_valid;
  logic   ir_ready;
  instr_t ir_instr;
  addr_t  ir_pc;
  logic   jump_en;
  addr_t  jump_target;
  logic   call_en;
  logic   ret_en;

  modport master (
    output imem_addr, ir_valid, ir_instr, ir_pc,
    input  imem_instr, ir_ready,
    input  jump_en, jump_target, call_en, ret_en
  );

  modport slave (
    input  imem_addr, ir_valid, ir_instr, ir_pc,
    output imem_instr, ir_ready,
    output jump_en, jump_target, call_en, ret_en
  );
endinterface

// File: rtl/fetch_sequencer_return_stack.sv
// LIFO return-address stack: registered count, combinational top.
// Contents are not reset; only the occupancy is.
module return_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 12,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] tp;

  assign wp    = count[PW-1:0];
  assign tp    = wp - PW'(1);
  assign top   = mem[tp];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push && !full) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// PC/IR fetch sequencer with jump/call/return redirects.
// Redirects drop the IR and cost one bubble; stack misuse is terminal.
module fetch_sequencer import fetch_pkg::*; #(
  parameter int    RAS_DEPTH = 8,
  parameter addr_t RESET_PC  = '0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  logic  halt_req,
  fetch_if.master bus,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic  fault,
  output logic  running
);
  fetch_state_t state, state_n;
  addr_t  pc, pc_n;
  logic   irv, irv_n;
  instr_t iri, iri_n;
  addr_t  irp, irp_n;
  logic   flt_n;
  logic   push, pop;
  addr_t  ras_top;
  logic   ras_full, ras_empty;

  return_stack #(
    .DEPTH(RAS_DEPTH),
    .W    (ADDR_W)
  ) u_ras (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (irp + addr_t'(1)),
    .top  (ras_top),
    .count(ras_count),
    .full (ras_full),
    .empty(ras_empty)
  );

  assign bus.imem_addr = pc;
  assign bus.ir_valid  = irv;
  assign bus.ir_instr  = iri;
  assign bus.ir_pc     = irp;
  assign running       = (state == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      irv   <= 1'b0;
      iri   <= '0;
      irp   <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      irv   <= irv_n;
      iri   <= iri_n;
      irp   <= irp_n;
      fault <= flt_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    irv_n   = irv;
    iri_n   = iri;
    irp_n   = irp;
    flt_n   = fault;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        if (bus.ret_en) begin
          irv_n = 1'b0;
          if (ras_empty) begin
            state_n = FAULT;
            flt_n   = 1'b1;
          end else begin
            pop  = 1'b1;
            pc_n = ras_top;
          end
        end else if (bus.call_en) begin
          irv_n = 1'b0;
          if (ras_full) begin
            state_n = FAULT;
            flt_n   = 1'b1;
          end else begin
            push = 1'b1;
            pc_n = bus.jump_target;
          end
        end else if (bus.jump_en) begin
          irv_n = 1'b0;
          pc_n  = bus.jump_target;
        end else if (halt_req) begin
          state_n = HALT;
        end else if (!irv || bus.ir_ready) begin
          irv_n = 1'b1;
          iri_n = bus.imem_instr;
          irp_n = pc;
          pc_n  = pc + addr_t'(1);
        end
      end
      HALT: begin
        // decode may still drain the held IR while halted
        if (bus.ir_ready) irv_n = 1'b0;
        if (start) state_n = RUN;
      end
      FAULT: begin
        irv_n = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer against a queue-based model.
// Memory holds random words so ir_instr is tied to the fetched address.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int RD = 8;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic halt_req;
  logic [3:0] ras_count;
  logic fault;
  logic running;

  instr_t mem [4096];

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int     m_st;
  addr_t  m_pc;
  logic   m_v;
  instr_t m_ir;
  addr_t  m_irpc;
  logic   m_flt;
  addr_t  ras [$];

  fetch_if bus ();

  assign bus.imem_instr = mem[bus.imem_addr];

  fetch_sequencer #(
    .RAS_DEPTH(RD),
    .RESET_PC ('0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .halt_req (halt_req),
    .bus      (bus),
    .ras_count(ras_count),
    .fault    (fault),
    .running  (running)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_st   = 0;
    m_pc   = '0;
    m_v    = 1'b0;
    m_ir   = '0;
    m_irpc = '0;
    m_flt  = 1'b0;
    ras.delete();
  endtask

  task automatic model_step();
    case (m_st)
      0: if (start) m_st = 1;
      1: begin
        if (bus.ret_en) begin
          m_v = 1'b0;
          if (ras.size() == 0) begin
            m_st = 3; m_flt = 1'b1;
          end else begin
            m_pc = ras.pop_back();
          end
        end else if (bus.call_en) begin
          m_v = 1'b0;
          if (ras.size() == RD) begin
            m_st = 3; m_flt = 1'b1;
          end else begin
            ras.push_back(addr_t'((int'(m_irpc) + 1) % 4096));
            m_pc = bus.jump_target;
          end
        end else if (bus.jump_en) begin
          m_v = 1'b0; m_pc = bus.jump_target;
        end else if (halt_req) begin
          m_st = 2;
        end else if (!m_v || bus.ir_ready) begin
          m_v = 1'b1; m_ir = mem[m_pc]; m_irpc = m_pc;
          m_pc = addr_t'((int'(m_pc) + 1) % 4096);
        end
      end
      2: begin
        if (bus.ir_ready) m_v = 1'b0;
        if (start) m_st = 1;
      end
      default: m_v = 1'b0;
    endcase
  endtask

  function automatic logic [49:0] mvec();
    return {m_v, m_irpc, m_ir, 4'(ras.size()), m_flt,
            m_st == 1, m_pc};
  endfunction

  function automatic logic [49:0] dvec();
    return {bus.ir_valid, bus.ir_pc, bus.ir_instr, ras_count,
            fault, running, bus.imem_addr};
  endfunction

  task automatic clear_in();
    start = 0; halt_req = 0;
    bus.ir_ready = 0; bus.jump_en = 0; bus.call_en = 0;
    bus.ret_en = 0; bus.jump_target = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 0;
    clear_in();
    #2;
    model_reset();
    @(negedge clk);
    rst = 1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    clear_in();
    rst = 0;
    #12;
    model_reset();
    n_chk++;
    if (dvec() !== 50'd0) begin
      n_fail++;
      $display("FAIL reset: got %h want %h", dvec(), 50'd0);
    end
    @(negedge clk);
    rst = 1;
    tick();
  endtask

  task automatic test_stream();
    pulse_start();
    n_chk++;
    if (bus.ir_valid !== 1'b0 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL start_edge: got v%b r%b want v0 r1",
               bus.ir_valid, running);
    end
    bus.ir_ready = 1;
    for (int i = 0; i < 30 && !(m_v && m_irpc == 5); i++) begin
      tick();
      n_chk++;
      if (dvec() !== mvec()) begin
        n_fail++;
        $display("FAIL stream: got %h want %h", dvec(), mvec());
      end
    end
  endtask

  task automatic test_stall();
    bus.ir_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (bus.ir_pc !== 12'd5 || bus.imem_addr !== 12'd6 ||
          dvec() !== mvec()) begin
        n_fail++;
        $display("FAIL stall: got pc%0d addr%0d want 5/6",
                 bus.ir_pc, bus.imem_addr);
      end
    end
    bus.ir_ready = 1;
    tick();
    n_chk++;
    if (bus.ir_pc !== 12'd6 || dvec() !== mvec()) begin
      n_fail++;
      $display("FAIL stall_release: got %0d want 6", bus.ir_pc);
    end
  endtask

  task automatic test_call_ret();
    bus.ir_ready = 1;
    for (int i = 0; i < 30 && m_irpc != 10; i++) tick();
    bus.call_en = 1;
    bus.jump_target = 12'h200;
    tick();
    bus.call_en = 0;
    n_chk++;
    if (bus.ir_valid !== 1'b0 || ras_count !== 4'd1) begin
      n_fail++;
      $display("FAIL call_bubble: got v%b n%0d want v0 n1",
               bus.ir_valid, ras_count);
    end
    tick();
    n_chk++;
    if (bus.ir_pc !== 12'h200 || dvec() !== mvec()) begin
      n_fail++;
      $display("FAIL call_target: got %h want 200", bus.ir_pc);
    end
    for (int i = 0; i < 3; i++) tick();
    bus.ret_en = 1;
    tick();
    bus.ret_en = 0;
    tick();
    n_chk++;
    if (bus.ir_pc !== 12'd11 || ras_count !== 4'd0 ||
        dvec() !== mvec()) begin
      n_fail++;
      $display("FAIL ret: got pc%0d n%0d want pc11 n0",
               bus.ir_pc, ras_count);
    end
  endtask

  task automatic test_wrap();
    bus.jump_en = 1;
    bus.jump_target = 12'hfff;
    tick();
    bus.jump_en = 0;
    tick();
    n_chk++;
    if (bus.ir_pc !== 12'hfff || bus.ir_instr !== mem[4095]) begin
      n_fail++;
      $display("FAIL wrap_hi: got %h want fff", bus.ir_pc);
    end
    tick();
    n_chk++;
    if (bus.ir_pc !== 12'd0 || dvec() !== mvec()) begin
      n_fail++;
      $display("FAIL wrap_lo: got %h want 000", bus.ir_pc);
    end
  endtask

  task automatic test_halt();
    bus.ir_ready = 1;
    for (int i = 0; i < 40 && m_irpc != 20; i++) tick();
    halt_req = 1;
    tick();
    halt_req = 0;
    bus.ir_ready = 0;
    tick();
    n_chk++;
    if (bus.ir_pc !== 12'd20 || running !== 1'b0 ||
        bus.ir_valid !== 1'b1 || dvec() !== mvec()) begin
      n_fail++;
      $display("FAIL halt: got pc%0d r%b want pc20 r0",
               bus.ir_pc, running);
    end
    bus.ir_ready = 1;
    tick();
    n_chk++;
    if (bus.ir_valid !== 1'b0 || bus.ir_pc !== 12'd20) begin
      n_fail++;
      $display("FAIL halt_drain: got v%b want v0", bus.ir_valid);
    end
    pulse_start();
    tick();
    n_chk++;
    if (bus.ir_pc !== 12'd21 || running !== 1'b1 ||
        dvec() !== mvec()) begin
      n_fail++;
      $display("FAIL resume: got pc%0d want 21", bus.ir_pc);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    pulse_start();
    bus.ir_ready = 1;
    tick();
    bus.call_en = 1;
    for (int i = 0; i < RD + 1; i++) begin
      bus.jump_target = addr_t'($urandom);
      tick();
      n_chk++;
      if (dvec() !== mvec()) begin
        n_fail++;
        $display("FAIL nest%0d: got %h want %h", i, dvec(), mvec());
      end
    end
    bus.call_en = 0;
    pulse_start();
    tick();
    n_chk++;
    if (fault !== 1'b1 || running !== 1'b0 ||
        bus.ir_valid !== 1'b0 || ras_count !== 4'd8) begin
      n_fail++;
      $display("FAIL overflow: got f%b r%b v%b want f1 r0 v0",
               fault, running, bus.ir_valid);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    pulse_start();
    bus.ret_en = 1;
    tick();
    bus.ret_en = 0;
    n_chk++;
    if (fault !== 1'b1 || running !== 1'b0 ||
        bus.imem_addr !== 12'd0) begin
      n_fail++;
      $display("FAIL underflow: got f%b r%b want f1 r0",
               fault, running);
    end
  endtask

  task automatic test_random();
    int r;
    apply_reset();
    pulse_start();
    for (int c = 0; c < 400; c++) begin
      if (m_st == 3 && $urandom_range(0, 3) == 0) apply_reset();
      r = $urandom_range(0, 99);
      bus.ir_ready    = ($urandom_range(0, 3) != 0);
      bus.ret_en      = (r < 3);
      bus.call_en     = (r >= 2 && r < 7);
      bus.jump_en     = (r >= 6 && r < 11);
      halt_req        = (r >= 10 && r < 14) || (r == 2);
      start           = ($urandom_range(0, 7) == 0);
      bus.jump_target = addr_t'($urandom);
      tick();
      n_chk++;
      if (dvec() !== mvec()) begin
        n_fail++;
        $display("FAIL random c%0d: got %h want %h",
                 c, dvec(), mvec());
      end
    end
    clear_in();
  endtask

  task automatic test_async_reset();
    apply_reset();
    pulse_start();
    bus.ir_ready = 1;
    bus.call_en = 1;
    bus.jump_target = 12'h0a5;
    tick();
    bus.call_en = 0;
    for (int i = 0; i < 4; i++) tick();
    #3;
    rst = 0;
    #1;
    n_chk++;
    if (dvec() !== 50'd0) begin
      n_fail++;
      $display("FAIL async_rst: got %h want %h", dvec(), 50'd0);
    end
    model_reset();
    clear_in();
    @(negedge clk);
    rst = 1;
    tick();
    n_chk++;
    if (dvec() !== mvec()) begin
      n_fail++;
      $display("FAIL post_rst: got %h want %h", dvec(), mvec());
    end
  endtask

  initial begin
    rst = 0;
    for (int i = 0; i < 4096; i++) mem[i] = instr_t'($urandom);
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_call_ret();
    test_wrap();
    test_halt();
    test_overflow();
    test_underflow();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
